// File: rtl/change_dispenser.sv
`default_nettype none
// ============================================================================
// Module   : change_dispenser
// Brief    : Returns a balance as coins, largest eligible coin first, one coin
//            per cycle, then pulses o_done with any undispensable remainder.
//            Optional per-denomination stock counters: CHANGE_INVENTORY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module change_dispenser #(
    parameter int COIN0_VAL  = 100,
    parameter int COIN1_VAL  = 500,
    parameter int COIN2_VAL  = 1000,
    parameter int TOTAL_BITS = 31,
    parameter int INIT_STOCK = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_return_req,
    input  logic [TOTAL_BITS-1:0] i_balance,
    output logic                  o_busy,
    output logic [2:0]            o_return_coin,
    output logic                  o_done,
    output logic [TOTAL_BITS-1:0] o_residual
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPENSE = 2'd1,
        DONE     = 2'd2
    } state_t;

    localparam logic [TOTAL_BITS-1:0] c_coin0 = TOTAL_BITS'(COIN0_VAL);
    localparam logic [TOTAL_BITS-1:0] c_coin1 = TOTAL_BITS'(COIN1_VAL);
    localparam logic [TOTAL_BITS-1:0] c_coin2 = TOTAL_BITS'(COIN2_VAL);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [TOTAL_BITS-1:0]   r_remaining;
    logic [TOTAL_BITS-1:0]   w_remaining_nxt;
    logic [2:0]              w_coin_nxt;
    logic                    w_done_nxt;
    logic [TOTAL_BITS-1:0]   w_residual_nxt;
    logic                    w_busy_nxt;
    logic [2:0]              w_stock_ok;
    logic [2:0]              w_eligible;

`ifdef CHANGE_INVENTORY_EN
    localparam int STOCK_W = (INIT_STOCK < 1) ? 1 : $clog2(INIT_STOCK + 1);

    logic [STOCK_W-1:0] r_stock [3];

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_stock
            assign w_stock_ok[gi] = (r_stock[gi] != '0);

            // Count down on every coin of this denomination, never below zero.
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    r_stock[gi] <= STOCK_W'(INIT_STOCK);
                end else if (w_coin_nxt[gi] && (r_stock[gi] != '0)) begin
                    r_stock[gi] <= r_stock[gi] - STOCK_W'(1);
                end
            end
        end
    endgenerate
`else
    // Unlimited supply: every denomination is always available.
    assign w_stock_ok = 3'b111;
`endif

    // A coin is usable when it fits in the remaining amount and is in stock.
    assign w_eligible[0] = (r_remaining >= c_coin0) && w_stock_ok[0];
    assign w_eligible[1] = (r_remaining >= c_coin1) && w_stock_ok[1];
    assign w_eligible[2] = (r_remaining >= c_coin2) && w_stock_ok[2];

    // State register and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_remaining   <= '0;
            o_busy        <= 1'b0;
            o_return_coin <= 3'b000;
            o_done        <= 1'b0;
            o_residual    <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_remaining   <= w_remaining_nxt;
            o_busy        <= w_busy_nxt;
            o_return_coin <= w_coin_nxt;
            o_done        <= w_done_nxt;
            o_residual    <= w_residual_nxt;
        end
    end

    // Next-state and next-output logic; greedy coin choice, largest first.
    always_comb begin
        w_state_nxt     = r_state;
        w_remaining_nxt = r_remaining;
        w_coin_nxt      = 3'b000;
        w_done_nxt      = 1'b0;
        w_residual_nxt  = '0;
        case (r_state)
            IDLE: begin
                if (i_return_req) begin
                    w_remaining_nxt = i_balance;
                    w_state_nxt     = DISPENSE;
                end
            end
            DISPENSE: begin
                if (w_eligible[2]) begin
                    w_coin_nxt      = 3'b100;
                    w_remaining_nxt = r_remaining - c_coin2;
                end else if (w_eligible[1]) begin
                    w_coin_nxt      = 3'b010;
                    w_remaining_nxt = r_remaining - c_coin1;
                end else if (w_eligible[0]) begin
                    w_coin_nxt      = 3'b001;
                    w_remaining_nxt = r_remaining - c_coin0;
                end else begin
                    w_done_nxt      = 1'b1;
                    w_residual_nxt  = r_remaining;
                    w_remaining_nxt = '0;
                    w_state_nxt     = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt     = IDLE;
                w_remaining_nxt = '0;
            end
        endcase
        w_busy_nxt = (w_state_nxt != IDLE);
    end

endmodule
`default_nettype wire
